// File: rtl/jt12_lfo_pkg.sv
// Shared LFO definitions: prescaler limit table, PM width, rate lookup and control decode.
// Used by jt12_lfo_gen and jt12_lfo_shape.
package jt12_lfo_pkg;

    localparam int unsigned PM_W  = 5;
    localparam int unsigned LIM_W = 7;

    // Zero-strobe limit per lfo_freq; one phase step every limit+1 strobes
    localparam logic [LIM_W-1:0] LFO_LIMIT [8] = '{
        7'd108, 7'd78, 7'd71, 7'd67, 7'd62, 7'd44, 7'd8, 7'd5
    };

    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_RESTART,
        ACT_DISABLE,
        ACT_COUNT
    } lfo_act_e;

    function automatic logic [LIM_W-1:0] lfo_limit(input logic [2:0] rate);
        return LFO_LIMIT[rate];
    endfunction

endpackage

// File: rtl/jt12_lfo_shape.sv
// Registered phase -> AM triangle / PM step index mapping for the LFO.
// Only instanced when JT12_LFO_WAVE_EN is defined.
module jt12_lfo_shape
    import jt12_lfo_pkg::*;
#(
    parameter int unsigned MW = 7
)(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clk_en,
    input  logic            i_clr,
    input  logic [MW-1:0]   i_phase,
    output logic [MW-2:0]   o_am,
    output logic [PM_W-1:0] o_pm
);

    logic [MW-2:0]   w_am;
    logic [MW-2:0]   r_am;
    logic [PM_W-1:0] r_pm;

    // Upper half of the phase folds back so the AM output is a triangle
    assign w_am = i_phase[MW-1] ? ~i_phase[MW-2:0] : i_phase[MW-2:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_am <= '0;
            r_pm <= '0;
        end else if (i_clr) begin
            r_am <= '0;
            r_pm <= '0;
        end else if (i_clk_en) begin
            r_am <= w_am;
            r_pm <= i_phase[MW-1 -: PM_W];
        end
    end

    assign o_am = r_am;
    assign o_pm = r_pm;

endmodule

// File: rtl/jt12_lfo_gen.sv
// Parametrised FM LFO: prescales the zero strobe by a rate limit and advances an MW-bit phase.
// Define JT12_LFO_WAVE_EN to build the registered AM/PM shaping; otherwise lfo_am/lfo_pm are 0.
module jt12_lfo_gen
    import jt12_lfo_pkg::*;
#(
    parameter int unsigned CW   = 7,
    parameter int unsigned MW   = 7,
    parameter int unsigned HOLD = 0
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            zero,
    input  logic            lfo_en,
    input  logic            lfo_rst,
    input  logic [2:0]      lfo_freq,
    output logic [MW-1:0]   lfo_phase,
    output logic            lfo_tick,
    output logic [MW-2:0]   lfo_am,
    output logic [PM_W-1:0] lfo_pm
);

    lfo_act_e      w_act;
    logic [CW-1:0] w_limit;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [MW-1:0] r_phase;
    logic [MW-1:0] w_phase_nxt;
    logic          r_tick;
    logic          w_tick_nxt;

    assign w_limit = CW'(lfo_limit(lfo_freq));

    // Restart ignores clk_en; disable and counting are clk_en-qualified
    always_comb begin
        w_act = ACT_IDLE;
        if (lfo_rst) begin
            w_act = ACT_RESTART;
        end else if (!lfo_en) begin
            if (clk_en) w_act = ACT_DISABLE;
        end else if (clk_en && zero) begin
            w_act = ACT_COUNT;
        end
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_tick_nxt  = 1'b0;
        case (w_act)
            ACT_RESTART: begin
                w_cnt_nxt   = '0;
                w_phase_nxt = '0;
            end
            ACT_DISABLE: begin
                if (HOLD == 0) begin
                    w_cnt_nxt   = '0;
                    w_phase_nxt = '0;
                end
            end
            ACT_COUNT: begin
                // >= so a count left above a newly lowered limit wraps at once
                if (r_cnt >= w_limit) begin
                    w_cnt_nxt   = '0;
                    w_phase_nxt = r_phase + MW'(1);
                    w_tick_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    assign lfo_phase = r_phase;
    assign lfo_tick  = r_tick;

`ifdef JT12_LFO_WAVE_EN
    logic w_shape_clr;

    assign w_shape_clr = (w_act == ACT_RESTART) || ((w_act == ACT_DISABLE) && (HOLD == 0));

    jt12_lfo_shape #(
        .MW (MW)
    ) u_shape (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clk_en (clk_en),
        .i_clr    (w_shape_clr),
        .i_phase  (r_phase),
        .o_am     (lfo_am),
        .o_pm     (lfo_pm)
    );
`else
    assign lfo_am = '0;
    assign lfo_pm = '0;
`endif

endmodule

// File: tb/tb_jt12_lfo_gen.sv
// Directed self-checking bench for jt12_lfo_gen: one HOLD=0 and one HOLD=1 instance on shared stimulus.
module tb_jt12_lfo_gen;
    import jt12_lfo_pkg::*;

    localparam int unsigned MW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clk_en;
    logic            zero;
    logic            lfo_en;
    logic            lfo_rst;
    logic [2:0]      lfo_freq;

    logic [MW-1:0]   d0_phase, d1_phase;
    logic            d0_tick,  d1_tick;
    logic [MW-2:0]   d0_am,    d1_am;
    logic [PM_W-1:0] d0_pm,    d1_pm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jt12_lfo_gen #(.CW(7), .MW(MW), .HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero), .lfo_en(lfo_en),
        .lfo_rst(lfo_rst), .lfo_freq(lfo_freq), .lfo_phase(d0_phase), .lfo_tick(d0_tick),
        .lfo_am(d0_am), .lfo_pm(d0_pm)
    );

    jt12_lfo_gen #(.CW(7), .MW(MW), .HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero), .lfo_en(lfo_en),
        .lfo_rst(lfo_rst), .lfo_freq(lfo_freq), .lfo_phase(d1_phase), .lfo_tick(d1_tick),
        .lfo_am(d1_am), .lfo_pm(d1_pm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart();
        lfo_rst = 1'b1;
        step(1);
        lfo_rst = 1'b0;
    endtask

    // Triangle: rises 0..63 over phases 0..63, falls 63..0 over phases 64..127
    function automatic logic [31:0] am_exp(input int unsigned p);
`ifdef JT12_LFO_WAVE_EN
        return (p < 64) ? 32'(p) : 32'(127 - p);
`else
        return 32'(p & 0);
`endif
    endfunction

    function automatic logic [31:0] pm_exp(input int unsigned p);
`ifdef JT12_LFO_WAVE_EN
        return 32'(p / 4);
`else
        return 32'(p & 0);
`endif
    endfunction

    initial begin
        rst_n    = 1'b0;
        clk_en   = 1'b1;
        zero     = 1'b1;
        lfo_en   = 1'b1;
        lfo_rst  = 1'b0;
        lfo_freq = 3'd7;
        step(3);
        chk("rst_phase", 32'(d0_phase), 0);
        chk("rst_tick",  32'(d0_tick),  0);
        chk("rst_am",    32'(d0_am),    0);
        chk("rst_pm",    32'(d0_pm),    0);
        chk("rst_phase1", 32'(d1_phase), 0);

        // Fastest rate: one step every 6 strobes
        rst_n = 1'b1;
        for (int unsigned i = 1; i <= 12; i++) begin
            step(1);
            chk("f7_tick",  32'(d0_tick),  32'(i % 6 == 0));
            chk("f7_phase", 32'(d0_phase), 32'(i / 6));
            if (i == 6) chk("f7_am_lat_a", 32'(d0_am), 0);
            if (i == 7) chk("f7_am_lat_b", 32'(d0_am), am_exp(1));
        end

        // Asynchronous reset mid-count
        step(3);
        rst_n = 1'b0;
        #1;
        chk("arst_phase", 32'(d0_phase), 0);
        chk("arst_tick",  32'(d0_tick),  0);
        chk("arst_am",    32'(d0_am),    0);
        chk("arst_pm",    32'(d0_pm),    0);
        step(2);
        chk("arst_hold_phase", 32'(d0_phase), 0);
        rst_n = 1'b1;
        zero  = 1'b0;
        step(3);
        chk("rel_nozero_phase", 32'(d0_phase), 0);
        chk("rel_nozero_tick",  32'(d0_tick),  0);
        zero = 1'b1;
        step(5);
        chk("rel_5_tick",  32'(d0_tick),  0);
        chk("rel_5_phase", 32'(d0_phase), 0);
        step(1);
        chk("rel_6_tick",  32'(d0_tick),  1);
        chk("rel_6_phase", 32'(d0_phase), 1);
        step(1);
        chk("tick_one_cycle", 32'(d0_tick), 0);

        // clk_en low freezes counting
        clk_en = 1'b0;
        step(10);
        chk("clken_phase", 32'(d0_phase), 1);
        chk("clken_tick",  32'(d0_tick),  0);
        clk_en = 1'b1;

        // Slowest rate: first increment at strobe 109
        restart();
        chk("lrst_phase", 32'(d0_phase), 0);
        lfo_freq = 3'd0;
        step(108);
        chk("f0_108_tick",  32'(d0_tick),  0);
        chk("f0_108_phase", 32'(d0_phase), 0);
        step(1);
        chk("f0_109_tick",  32'(d0_tick),  1);
        chk("f0_109_phase", 32'(d0_phase), 1);

        // Rate lowered while count is above the new limit
        restart();
        lfo_freq = 3'd0;
        step(50);
        chk("rc_pre_phase", 32'(d0_phase), 0);
        lfo_freq = 3'd7;
        step(1);
        chk("rc_wrap_tick",  32'(d0_tick),  1);
        chk("rc_wrap_phase", 32'(d0_phase), 1);
        step(5);
        chk("rc_5_tick", 32'(d0_tick), 0);
        step(1);
        chk("rc_6_tick",  32'(d0_tick),  1);
        chk("rc_6_phase", 32'(d0_phase), 2);

        // Disable at phase 20: clear vs hold
        restart();
        step(120);
        chk("dis_pre_phase0", 32'(d0_phase), 20);
        chk("dis_pre_phase1", 32'(d1_phase), 20);
        step(2);
        lfo_en = 1'b0;
        step(3);
        chk("dis_clr_phase",  32'(d0_phase), 0);
        chk("dis_hold_phase", 32'(d1_phase), 20);
        chk("dis_clr_tick",   32'(d0_tick),  0);
        chk("dis_hold_tick",  32'(d1_tick),  0);
        chk("dis_clr_am",     32'(d0_am),    0);
        chk("dis_hold_am",    32'(d1_am),    am_exp(20));
        lfo_en = 1'b1;
        step(3);
        chk("res_hold_3_tick",  32'(d1_tick),  0);
        chk("res_hold_3_phase", 32'(d1_phase), 20);
        step(1);
        chk("res_hold_4_tick",  32'(d1_tick),  1);
        chk("res_hold_4_phase", 32'(d1_phase), 21);
        chk("res_clr_4_tick",   32'(d0_tick),  0);
        step(2);
        chk("res_clr_6_tick",  32'(d0_tick),  1);
        chk("res_clr_6_phase", 32'(d0_phase), 1);

        // lfo_rst at phase 40, with clk_en low
        restart();
        step(240);
        chk("rs_pre_phase", 32'(d0_phase), 40);
        step(2);
        clk_en  = 1'b0;
        lfo_rst = 1'b1;
        step(1);
        lfo_rst = 1'b0;
        clk_en  = 1'b1;
        chk("rs_phase0", 32'(d0_phase), 0);
        chk("rs_phase1", 32'(d1_phase), 0);
        chk("rs_tick",   32'(d0_tick),  0);
        chk("rs_am",     32'(d0_am),    0);
        chk("rs_pm",     32'(d0_pm),    0);
        step(5);
        chk("rs_5_tick", 32'(d1_tick), 0);
        step(1);
        chk("rs_6_tick",  32'(d1_tick),  1);
        chk("rs_6_phase", 32'(d1_phase), 1);

        // Full phase sweep with waveform checks and wrap
        restart();
        for (int unsigned s = 1; s <= 768; s++) begin
            step(1);
            if (s % 6 == 0) begin
                chk("sw_tick",  32'(d0_tick),  1);
                chk("sw_phase", 32'(d0_phase), 32'((s / 6) % 128));
            end else if (s % 6 == 3) begin
                chk("sw_am", 32'(d0_am), am_exp(s / 6));
                chk("sw_pm", 32'(d0_pm), pm_exp(s / 6));
`ifdef JT12_LFO_WAVE_EN
                if (s / 6 == 0)   chk("sw_am_p0",   32'(d0_am), 0);
                if (s / 6 == 63)  chk("sw_am_p63",  32'(d0_am), 63);
                if (s / 6 == 64)  chk("sw_am_p64",  32'(d0_am), 63);
                if (s / 6 == 127) chk("sw_am_p127", 32'(d0_am), 0);
                if (s / 6 == 127) chk("sw_pm_p127", 32'(d0_pm), 31);
`else
                if (s / 6 == 64)  chk("sw_am_off", 32'(d0_am), 0);
`endif
            end
        end
        chk("wrap_phase", 32'(d0_phase), 0);
        chk("wrap_tick",  32'(d0_tick),  1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt12_lfo_gen.md
# jt12_lfo_gen

Parametrised low-frequency oscillator for the FM core. It divides the sample-rate `zero` strobe by a rate-dependent limit and advances an MW-bit LFO phase. It also produces registered AM (triangle) and PM (step index) modulation values plus a one-cycle tick. It sits beside the operator pipeline and feeds the envelope (AM) and phase-generator (PM) stages. Compared with the fixed 7-bit LFO, it adds:

- width parameters;
- hold-vs-clear disable mode;
- an explicit phase restart;
- defined behaviour when the rate changes mid-count;
- built-in waveform shaping.

## Interface
Parameters:
- CW, 7 — prescaler counter width; must hold the largest limit (≥7).
- MW, 7 — LFO phase width, 5..10.
- HOLD, 0 — 0: lfo_en low clears counter and phase; 1: lfo_en low freezes them.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- clk_en  in  1  clock enable qualifying all state updates.
- zero  in  1  once-per-sample strobe, sampled only with clk_en.
- lfo_en  in  1  LFO enable.
- lfo_rst  in  1  synchronous restart of counter and phase.
- lfo_freq  in  3  rate select.
- lfo_phase  out  MW  raw LFO phase.
- lfo_tick  out  1  one-cycle pulse on every phase increment.
- lfo_am  out  MW-1  triangle amplitude modulation.
- lfo_pm  out  5  PM step index.

## Operation
- Limit table by lfo_freq 0..7: 108, 78, 71, 67, 62, 44, 8, 5. Period per phase step = limit+1 zero-strobes.
- Priority, highest first:
  1. rst_n low: all registers and outputs are 0.
  2. lfo_rst high: cnt and phase cleared, tick 0. Acts regardless of clk_en.
  3. lfo_en low: HOLD=0 clears cnt and phase; HOLD=1 keeps both. Tick is 0 in both modes.
  4. Counting, when clk_en and zero are both high:
     - cnt ≥ limit: cnt←0, phase←phase+1 (mod 2^MW), tick←1.
     - otherwise: cnt←cnt+1.
- Otherwise tick←0.
- Rate change mid-count: the terminal condition is cnt ≥ limit. A count already past the new limit wraps on the next qualified strobe and never runs to 2^CW.
- Phase wrap: 2^MW−1 → 0 with no extra event. The tick still fires.
- lfo_am: if phase[MW-1] is 1, ~phase[MW-2:0]; else phase[MW-2:0]. Range 0..2^(MW-1)−1.
- lfo_pm = phase[MW-1:MW-5].
- Both waveform outputs are registered from the phase. They are cleared with the phase on reset, lfo_rst, or a HOLD=0 disable.

## Timing
- Counter and phase update on the clk edge where clk_en&zero is sampled high.
- lfo_phase and lfo_tick are valid after that edge (latency 1).
- lfo_am and lfo_pm follow lfo_phase one clk_en-qualified cycle later (latency 2). They update whenever clk_en is high, independent of zero.
- lfo_tick is high for exactly one clk cycle per increment, even if clk_en stays high.
- lfo_freq is sampled every counting cycle; a change takes effect on the next qualified strobe.
- Reset deassertion is synchronised by the system. The first count occurs on the first qualified strobe after release.

## Configuration
- JT12_LFO_WAVE_EN defined: the AM/PM shaping registers are built and lfo_am/lfo_pm behave as above.
- JT12_LFO_WAVE_EN undefined: lfo_am and lfo_pm are tied to 0 and no shaping logic is built. lfo_phase and lfo_tick are unaffected.

## Structure
- Shared package jt12_lfo_pkg holds:
  - the 8-entry limit table constant;
  - the localparam PM_W = 5;
  - a function returning the limit for a 3-bit rate.
- One sub-module, jt12_lfo_shape, holds the registered phase→AM/PM mapping. It is instanced only under JT12_LFO_WAVE_EN.

## Test plan
- Reset: hold rst_n low mid-count with clk toggling → all outputs 0 immediately. They stay 0 until the first qualified strobe after release.
- Rate check: lfo_freq=7, lfo_en=1, zero every cycle → lfo_tick every 6th cycle. lfo_phase=1 after 6 strobes and 2 after 12. With lfo_freq=0, the first increment comes at strobe 109.
- Rate change: lfo_freq=0, run until cnt=50, then switch to lfo_freq=7 → the next strobe gives cnt=0, phase+1 and a tick.
- Disable and restart:
  - HOLD=0: drop lfo_en at phase=20 → phase 0.
  - HOLD=1: same action → phase stays 20 and resumes from the same cnt.
  - lfo_rst pulse at phase=40 → phase 0 and cnt 0.
- Waveforms, MW=7, phase swept 0..127 → lfo_am is 0 at phase 0, 63 at phases 63 and 64, and 0 at phase 127. lfo_pm=phase>>2. After 127, phase wraps to 0 with a tick.
- Macro off: build without JT12_LFO_WAVE_EN → lfo_am and lfo_pm stay 0 during the same sweep, and the phase sequence is identical.
